// File: rtl/tx_symbol_mux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tx_symbol_mux_pkg : shared mode encodings for the Tx symbol mux  | rev 1.0 |
// +----------------------------------------------------------------------------+
package tx_symbol_mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

endpackage : tx_symbol_mux_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter : round-robin grant search starting after the last winner | rev 1.0 |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NCH  = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NCH-1:0]  req_i,
  input  logic            en_i,
  output logic [NCH-1:0]  gnt_o,
  output logic [SELW-1:0] idx_o,
  output logic            valid_o
);

  logic [SELW-1:0] ptr_q;
  logic [SELW-1:0] ptr_d;
  logic [SELW:0]   sum;
  logic [SELW-1:0] cand;

  // Search ptr+1 .. ptr+NCH (mod NCH); the first requester found wins.
  always_comb begin
    sum     = '0;
    cand    = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    gnt_o   = '0;
    for (int k = 1; k <= NCH; k++) begin
      sum = {1'b0, ptr_q} + (SELW+1)'(k);
      if (sum >= (SELW+1)'(NCH)) sum = sum - (SELW+1)'(NCH);
      cand = sum[SELW-1:0];
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      gnt_o[i] = valid_o && (idx_o == SELW'(i));
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en_i && valid_o) ptr_d = idx_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= SELW'(NCH - 1);
    else        ptr_q <= ptr_d;
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/tx_symbol_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tx_symbol_mux : NCH-to-1 symbol mux, fixed-select or round-robin   | rev 1.0 |
// +----------------------------------------------------------------------------+
module tx_symbol_mux
  import tx_symbol_mux_pkg::*;
#(
  parameter int           NCH      = 4,
  parameter int           W        = 2,
  parameter logic [W-1:0] IDLE_SYM = '0,
  parameter int           SELW     = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_i,
  input  logic [SELW-1:0]   sel_i,
  input  logic [NCH*W-1:0]  in_data_i,
  input  logic [NCH-1:0]    in_valid_i,
  output logic [NCH-1:0]    in_ready_o,
  output logic [W-1:0]      out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [SELW-1:0]   out_ch_o
);

  logic [NCH-1:0]  w_fix_gnt;
  logic            w_fix_valid;
  logic [NCH-1:0]  w_rr_gnt;
  logic [SELW-1:0] w_rr_idx;
  logic            w_rr_valid;
  logic [NCH-1:0]  w_gnt;
  logic [SELW-1:0] w_gnt_idx;
  logic            w_gnt_valid;
  logic            w_free;
  logic            w_load;
  logic [W-1:0]    w_sym;

  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0] out_ch_q,    out_ch_d;

  // An out-of-range sel matches no channel, so it simply produces no grant.
  always_comb begin
    w_fix_gnt = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sel_i == SELW'(i)) w_fix_gnt[i] = in_valid_i[i];
    end
    w_fix_valid = |w_fix_gnt;
  end

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (in_valid_i),
    .en_i    (w_load && (mode_i == MODE_RR)),
    .gnt_o   (w_rr_gnt),
    .idx_o   (w_rr_idx),
    .valid_o (w_rr_valid)
  );

  always_comb begin
    if (mode_i == MODE_RR) begin
      w_gnt       = w_rr_gnt;
      w_gnt_idx   = w_rr_idx;
      w_gnt_valid = w_rr_valid;
    end else begin
      w_gnt       = w_fix_gnt;
      w_gnt_idx   = sel_i;
      w_gnt_valid = w_fix_valid;
    end
  end

  assign w_free     = !out_valid_q || out_ready_i;
  assign w_load     = w_free && w_gnt_valid;
  assign in_ready_o = w_load ? w_gnt : '0;

  always_comb begin
    w_sym = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_gnt[i]) w_sym = in_data_i[i*W +: W];
    end
  end

  // Drain without refill returns data to idle but keeps the last channel index.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (w_load) begin
      out_valid_d = 1'b1;
      out_data_d  = w_sym;
      out_ch_d    = w_gnt_idx;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
      out_data_d  = IDLE_SYM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= IDLE_SYM;
      out_ch_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_ch_o    = out_ch_q;

endmodule : tx_symbol_mux
`default_nettype wire

// File: tb/tb_tx_symbol_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tx_symbol_mux : directed scoreboard bench for tx_symbol_mux     | rev 1.0 |
// +----------------------------------------------------------------------------+
module tb_tx_symbol_mux;

  localparam int NCH  = 4;
  localparam int W    = 2;
  localparam int SELW = 2;

  logic            clk;
  logic            rst_n;
  logic            mode;
  logic [SELW-1:0] sel;
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]  in_valid;
  logic [NCH-1:0]  in_ready;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SELW-1:0] out_ch;

  int checks = 0;
  int errors = 0;
  logic [W+SELW-1:0] sb_q[$];

  tx_symbol_mux #(.NCH(NCH), .W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_i      (mode),
    .sel_i       (sel),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_ch_o    (out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] d, input logic [SELW-1:0] c);
    sb_q.push_back({d, c});
  endtask

  // A beat handshaken at the coming edge is popped and compared before the edge.
  task automatic step();
    logic [W+SELW-1:0] e;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_beat", {28'd0, out_data, out_ch}, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("sb_beat", {28'd0, out_data, out_ch}, {28'd0, e});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {30'd0, out_data}, 32'd0);
    chk("rst_ch", {30'd0, out_ch}, 32'd0);
    rst_n = 1'b1;

    // Fixed select on channel 2, then sel=3 with channel 3 idle.
    mode = 1'b0; sel = 2'd2; in_data = 8'h30; in_valid = 4'b0100; out_ready = 1'b1;
    #1;
    chk("fix_ready", {28'd0, in_ready}, 32'h4);
    push(2'b11, 2'd2);
    step();
    chk("fix_valid", {31'd0, out_valid}, 32'd1);
    chk("fix_data", {30'd0, out_data}, 32'h3);
    chk("fix_ch", {30'd0, out_ch}, 32'd2);
    in_valid = 4'b0000; sel = 2'd3;
    #1;
    chk("fix_noready", {28'd0, in_ready}, 32'h0);
    step();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_data", {30'd0, out_data}, 32'd0);
    chk("drain_ch_hold", {30'd0, out_ch}, 32'd2);

    // Round-robin with all channels valid: 0,1,2,3,0.
    mode = 1'b1; in_data = 8'hE4; in_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      #1;
      chk("rr_ready", {28'd0, in_ready}, 32'd1 << (n % 4));
      push(2'(n % 4), 2'(n % 4));
      step();
      chk("rr_valid", {31'd0, out_valid}, 32'd1);
      chk("rr_ch", {30'd0, out_ch}, 32'(n % 4));
    end
    in_valid = 4'b0000;
    step();

    // Only channels 1 and 3: 1,3,1.
    in_valid = 4'b1010;
    for (int n = 0; n < 3; n++) begin
      #1;
      push((n == 1) ? 2'd3 : 2'd1, (n == 1) ? 2'd3 : 2'd1);
      step();
      chk("rr13_ch", {30'd0, out_ch}, (n == 1) ? 32'd3 : 32'd1);
    end
    in_valid = 4'b0000;
    step();
    step();
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 4'b1111;
    #1;
    chk("ptr_hold_ready", {28'd0, in_ready}, 32'h4);
    push(2'b10, 2'd2);
    step();

    // Backpressure: beat 2'b10 held three cycles.
    out_ready = 1'b0;
    #1;
    chk("bp_ready0", {28'd0, in_ready}, 32'h0);
    for (int n = 0; n < 3; n++) begin
      step();
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_data", {30'd0, out_data}, 32'h2);
      chk("bp_ch", {30'd0, out_ch}, 32'd2);
      chk("bp_ready", {28'd0, in_ready}, 32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {28'd0, in_ready}, 32'h8);
    push(2'b11, 2'd3);
    step();
    chk("nobubble_valid", {31'd0, out_valid}, 32'd1);
    chk("nobubble_ch", {30'd0, out_ch}, 32'd3);

    // Mode switch while a beat is held.
    out_ready = 1'b0; mode = 1'b0; sel = 2'd1;
    step();
    chk("sw_hold_data", {30'd0, out_data}, 32'h3);
    chk("sw_hold_ch", {30'd0, out_ch}, 32'd3);
    chk("sw_hold_ready", {28'd0, in_ready}, 32'h0);
    out_ready = 1'b1;
    #1;
    chk("sw_ready", {28'd0, in_ready}, 32'h2);
    push(2'b01, 2'd1);
    step();
    chk("sw_data", {30'd0, out_data}, 32'h1);
    chk("sw_ch", {30'd0, out_ch}, 32'd1);

    // Reset in the middle of a held beat.
    out_ready = 1'b0; in_valid = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_data", {30'd0, out_data}, 32'd0);
    chk("mid_rst_ch", {30'd0, out_ch}, 32'd0);
    chk("mid_rst_ready", {28'd0, in_ready}, 32'h0);
    sb_q.delete();
    step();
    rst_n = 1'b1;
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    chk("post_rst_ready", {28'd0, in_ready}, 32'h1);
    push(2'b00, 2'd0);
    step();
    chk("post_rst_ch", {30'd0, out_ch}, 32'd0);
    in_valid = 4'b0000;
    step();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_tx_symbol_mux
`default_nettype wire
